// File: rtl/exp_aoi_capture_if.sv
// Bus bundle for exp_aoi_capture: AND/expander inputs and qualified AOI outputs.
interface exp_aoi_capture_if #(
  parameter int unsigned NUM_EXP = 2,
  parameter int unsigned NUM_AND = 2
);
  logic                   en;
  logic                   clr_fault;
  logic [4*NUM_AND-1:0]   and_in;
  logic [NUM_EXP-1:0]     exp_x;
  logic [NUM_EXP-1:0]     exp_xbar;
  logic                   y;
  logic                   y_valid;
  logic                   change;
  logic                   fault;
  logic [NUM_EXP-1:0]     fault_pair;

  modport master (
    output en, clr_fault, and_in, exp_x, exp_xbar,
    input  y, y_valid, change, fault, fault_pair
  );

  modport slave (
    input  en, clr_fault, and_in, exp_x, exp_xbar,
    output y, y_valid, change, fault, fault_pair
  );
endinterface

// File: rtl/exp_aoi_capture.sv
// Expandable AND-OR-INVERT capture stage: registers the AND terms and expander
// X/XBAR pairs, debounces the AOI result and flags non-complementary pairs.
// Optional: define EXP_AOI_TOGGLE_CNT_EN to add the saturating toggle_cnt output.
module exp_aoi_capture #(
  parameter int unsigned NUM_EXP       = 2,
  parameter int unsigned NUM_AND       = 2,
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned FAULT_LIMIT   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  exp_aoi_capture_if.slave       bus
`ifdef EXP_AOI_TOGGLE_CNT_EN
  ,
  output logic [7:0]             toggle_cnt
`endif
);

  localparam int unsigned AW = 4 * NUM_AND;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      and_q;
  logic [NUM_EXP-1:0] x_q, xb_q;
  logic [NUM_AND-1:0] and_term;
  logic [NUM_EXP-1:0] faulty_v;
  logic               any_faulty, raw;
  logic               cand, cand_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [CW-1:0]      fcnt, fcnt_inc, fcnt_nxt;
  logic               fault_hit, clr_ok;
  logic               y_q, y_nxt;
  logic               y_valid_q, y_valid_nxt;
  logic               change_q, change_nxt;
  logic               fault_q, fault_nxt;
  logic [NUM_EXP-1:0] fault_pair_q, fault_pair_nxt;

  // Input sample stage: one cycle of latency, everything below uses these copies
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      and_q <= '0;
      x_q   <= '0;
      xb_q  <= '0;
    end else begin
      and_q <= bus.and_in;
      x_q   <= bus.exp_x;
      xb_q  <= bus.exp_xbar;
    end
  end

  // Local 4-input AND terms
  always_comb begin
    and_term = '0;
    for (int k = 0; k < int'(NUM_AND); k++) begin
      and_term[k] = &and_q[4*k +: 4];
    end
  end

  assign faulty_v   = ~(x_q ^ xb_q);
  assign any_faulty = |faulty_v;
  assign raw        = ~((|and_term) | (|(x_q & ~xb_q)));
  assign fcnt_inc   = !any_faulty ? CW'(0) :
                      (fcnt == CW'(FAULT_LIMIT)) ? fcnt : CW'(fcnt + CW'(1));
  assign fault_hit  = (fcnt_inc == CW'(FAULT_LIMIT));
  assign clr_ok     = bus.clr_fault && !any_faulty;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cand         <= 1'b0;
      cnt          <= '0;
      fcnt         <= '0;
      y_q          <= 1'b1;
      y_valid_q    <= 1'b0;
      change_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_pair_q <= '0;
    end else begin
      state        <= state_nxt;
      cand         <= cand_nxt;
      cnt          <= cnt_nxt;
      fcnt         <= fcnt_nxt;
      y_q          <= y_nxt;
      y_valid_q    <= y_valid_nxt;
      change_q     <= change_nxt;
      fault_q      <= fault_nxt;
      fault_pair_q <= fault_pair_nxt;
    end
  end

  // Next state: fault detection beats EN low, which beats debounce
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    fcnt_nxt  = fcnt_inc;
    if (state == S_FAULT) begin
      if (clr_ok) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        fcnt_nxt  = '0;
      end
    end else if (fault_hit) begin
      state_nxt = S_FAULT;
    end else if (!bus.en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_ACQUIRE;
          cand_nxt  = raw;
          cnt_nxt   = CW'(1);
        end
        S_ACQUIRE: begin
          if (raw == cand) begin
            cnt_nxt = CW'(cnt + CW'(1));
          end else begin
            cand_nxt = raw;
            cnt_nxt  = CW'(1);
          end
          if (cnt_nxt == CW'(STABLE_CYCLES)) state_nxt = S_LOCKED;
        end
        S_LOCKED: begin
          if (raw != y_q) begin
            state_nxt = S_ACQUIRE;
            cand_nxt  = raw;
            cnt_nxt   = CW'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output next values: Y only moves on completion of an acquire
  always_comb begin
    y_nxt          = y_q;
    y_valid_nxt    = y_valid_q;
    change_nxt     = 1'b0;
    fault_nxt      = fault_q;
    fault_pair_nxt = fault_pair_q;
    if (state == S_FAULT) begin
      y_valid_nxt    = 1'b0;
      fault_pair_nxt = fault_pair_q | faulty_v;
      if (clr_ok) begin
        fault_nxt      = 1'b0;
        fault_pair_nxt = '0;
      end
    end else if (fault_hit) begin
      fault_nxt      = 1'b1;
      y_valid_nxt    = 1'b0;
      fault_pair_nxt = fault_pair_q | faulty_v;
    end else if (!bus.en || state == S_IDLE) begin
      y_valid_nxt = 1'b0;
    end else if (state == S_ACQUIRE && state_nxt == S_LOCKED) begin
      y_nxt       = cand_nxt;
      y_valid_nxt = 1'b1;
      change_nxt  = (cand_nxt != y_q);
    end
  end

`ifdef EXP_AOI_TOGGLE_CNT_EN
  // Saturating count of CHANGE pulses, cleared by reset only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else if (change_nxt && toggle_cnt != 8'hFF) begin
      toggle_cnt <= 8'(toggle_cnt + 8'd1);
    end
  end
`endif

  assign bus.y          = y_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.change     = change_q;
  assign bus.fault      = fault_q;
  assign bus.fault_pair = fault_pair_q;

endmodule

// File: tb/tb_exp_aoi_capture.sv
// Directed bench for exp_aoi_capture: lock, toggle, glitch, fault/clear, resets.
module tb_exp_aoi_capture;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   chk_cnt;

  exp_aoi_capture_if #(.NUM_EXP(2), .NUM_AND(2)) bus ();

`ifdef EXP_AOI_TOGGLE_CNT_EN
  logic [7:0] toggle_cnt;
`endif

  exp_aoi_capture #(
    .NUM_EXP(2), .NUM_AND(2), .STABLE_CYCLES(3), .FAULT_LIMIT(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef EXP_AOI_TOGGLE_CNT_EN
    ,
    .toggle_cnt (toggle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'($urandom_range(0, 1));
    bus.clr_fault = 1'($urandom_range(0, 1));
    bus.and_in = 8'($urandom);
    bus.exp_x = 2'($urandom);
    bus.exp_xbar = 2'($urandom);
    tick();
    tick();
    chk_cnt++; if (bus.y !== 1'b1) $display("FAIL rst_y: got %b exp 1", bus.y); else pass_cnt++;
    chk_cnt++; if (bus.y_valid !== 1'b0) $display("FAIL rst_y_valid: got %b exp 0", bus.y_valid); else pass_cnt++;
    chk_cnt++; if (bus.change !== 1'b0) $display("FAIL rst_change: got %b exp 0", bus.change); else pass_cnt++;
    chk_cnt++; if (bus.fault !== 1'b0) $display("FAIL rst_fault: got %b exp 0", bus.fault); else pass_cnt++;
    chk_cnt++; if (bus.fault_pair !== 2'b00) $display("FAIL rst_fault_pair: got %b exp 00", bus.fault_pair); else pass_cnt++;
  endtask

  task automatic test_first_lock();
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.clr_fault = 1'b0;
    bus.and_in = 8'h00;
    bus.exp_x = 2'b00;
    bus.exp_xbar = 2'b11;
    tick();
    tick();
    chk_cnt++; if (bus.y_valid !== 1'b0) $display("FAIL lock_early_valid: got %b exp 0", bus.y_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.y_valid !== 1'b1) $display("FAIL lock_valid: got %b exp 1", bus.y_valid); else pass_cnt++;
    chk_cnt++; if (bus.y !== 1'b1) $display("FAIL lock_y: got %b exp 1", bus.y); else pass_cnt++;
    chk_cnt++; if (bus.change !== 1'b0) $display("FAIL lock_change: got %b exp 0", bus.change); else pass_cnt++;
  endtask

  task automatic test_toggle();
    bus.and_in = 8'h0F;
    tick();
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk_cnt++; if (bus.change !== 1'b0 || bus.y !== 1'b1) $display("FAIL tog_hold%0d: got y=%b chg=%b exp y=1 chg=0", i, bus.y, bus.change); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (bus.y !== 1'b0) $display("FAIL tog_y: got %b exp 0", bus.y); else pass_cnt++;
    chk_cnt++; if (bus.change !== 1'b1) $display("FAIL tog_change: got %b exp 1", bus.change); else pass_cnt++;
    chk_cnt++; if (bus.y_valid !== 1'b1) $display("FAIL tog_valid: got %b exp 1", bus.y_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.change !== 1'b0) $display("FAIL tog_pulse_len: got %b exp 0", bus.change); else pass_cnt++;
    bus.and_in = 8'h00;
    tick();
    tick();
    tick();
    tick();
    chk_cnt++; if (bus.y !== 1'b1 || bus.change !== 1'b1) $display("FAIL tog_back: got y=%b chg=%b exp y=1 chg=1", bus.y, bus.change); else pass_cnt++;
    tick();
  endtask

  task automatic test_glitch();
    bus.exp_x = 2'b10;
    bus.exp_xbar = 2'b01;
    tick();
    tick();
    bus.exp_x = 2'b00;
    bus.exp_xbar = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_cnt++; if (bus.y !== 1'b1 || bus.change !== 1'b0 || bus.y_valid !== 1'b1) $display("FAIL glitch%0d: got y=%b chg=%b vld=%b exp 1/0/1", i, bus.y, bus.change, bus.y_valid); else pass_cnt++;
    end
  endtask

  task automatic test_fault_clear();
    bus.exp_x = 2'b01;
    bus.exp_xbar = 2'b11;
    tick();
    tick();
    chk_cnt++; if (bus.fault !== 1'b0) $display("FAIL flt_early: got %b exp 0", bus.fault); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.fault !== 1'b1) $display("FAIL flt_set: got %b exp 1", bus.fault); else pass_cnt++;
    chk_cnt++; if (bus.fault_pair !== 2'b01) $display("FAIL flt_pair: got %b exp 01", bus.fault_pair); else pass_cnt++;
    chk_cnt++; if (bus.y_valid !== 1'b0 || bus.y !== 1'b1) $display("FAIL flt_y: got y=%b vld=%b exp y=1 vld=0", bus.y, bus.y_valid); else pass_cnt++;
    bus.clr_fault = 1'b1;
    bus.exp_x = 2'b01;
    bus.exp_xbar = 2'b01;
    tick();
    chk_cnt++; if (bus.fault !== 1'b1 || bus.fault_pair !== 2'b01) $display("FAIL flt_clr_blocked: got f=%b p=%b exp 1/01", bus.fault, bus.fault_pair); else pass_cnt++;
    bus.exp_x = 2'b00;
    bus.exp_xbar = 2'b11;
    tick();
    chk_cnt++; if (bus.fault !== 1'b1 || bus.fault_pair !== 2'b11) $display("FAIL flt_sticky: got f=%b p=%b exp 1/11", bus.fault, bus.fault_pair); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.fault !== 1'b0 || bus.fault_pair !== 2'b00) $display("FAIL flt_cleared: got f=%b p=%b exp 0/00", bus.fault, bus.fault_pair); else pass_cnt++;
    chk_cnt++; if (bus.y_valid !== 1'b0 || bus.change !== 1'b0) $display("FAIL flt_idle: got vld=%b chg=%b exp 0/0", bus.y_valid, bus.change); else pass_cnt++;
    bus.clr_fault = 1'b0;
    tick();
    tick();
    tick();
    chk_cnt++; if (bus.y_valid !== 1'b1 || bus.y !== 1'b1 || bus.change !== 1'b0) $display("FAIL flt_relock: got y=%b vld=%b chg=%b exp 1/1/0", bus.y, bus.y_valid, bus.change); else pass_cnt++;
  endtask

  task automatic test_en_low();
    bus.en = 1'b0;
    tick();
    chk_cnt++; if (bus.y_valid !== 1'b0 || bus.y !== 1'b1 || bus.change !== 1'b0) $display("FAIL en_low: got y=%b vld=%b chg=%b exp 1/0/0", bus.y, bus.y_valid, bus.change); else pass_cnt++;
    bus.en = 1'b1;
    tick();
    tick();
    tick();
    chk_cnt++; if (bus.y_valid !== 1'b1) $display("FAIL en_relock: got %b exp 1", bus.y_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_acquire();
    bus.and_in = 8'h0F;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_cnt++; if (bus.y !== 1'b1 || bus.y_valid !== 1'b0 || bus.change !== 1'b0) $display("FAIL mid_rst: got y=%b vld=%b chg=%b exp 1/0/0", bus.y, bus.y_valid, bus.change); else pass_cnt++;
`ifdef EXP_AOI_TOGGLE_CNT_EN
    chk_cnt++; if (toggle_cnt !== 8'd0) $display("FAIL mid_rst_tcnt: got %0d exp 0", toggle_cnt); else pass_cnt++;
`endif
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_cnt++; if (bus.change !== 1'b0 || bus.y !== 1'b1) $display("FAIL mid_relock%0d: got y=%b chg=%b exp 1/0", i, bus.y, bus.change); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (bus.y !== 1'b0 || bus.change !== 1'b1 || bus.y_valid !== 1'b1) $display("FAIL mid_lock: got y=%b chg=%b vld=%b exp 0/1/1", bus.y, bus.change, bus.y_valid); else pass_cnt++;
`ifdef EXP_AOI_TOGGLE_CNT_EN
    chk_cnt++; if (toggle_cnt !== 8'd1) $display("FAIL mid_tcnt: got %0d exp 1", toggle_cnt); else pass_cnt++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    pass_cnt = 0;
    chk_cnt = 0;
    test_reset();
    test_first_lock();
    test_toggle();
    test_glitch();
    test_fault_clear();
    test_en_low();
    test_reset_mid_acquire();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
